// File: rtl/memn2n_phase_iterator_pkg.sv
// Shared constants for the MemN2N phase iterator: one-hot phase codes,
// default loop bounds and the iterator FSM state encoding.
// Phase bit order must match the upstream phase controller.
package memn2n_phase_iterator_pkg;

  localparam int BW_STATE_DEF  = 10;

  localparam logic [9:0] PHASE_IDLE            = 10'b00_0000_0001;
  localparam logic [9:0] PHASE_INIT            = 10'b00_0000_0010;
  localparam logic [9:0] PHASE_EMB_Q           = 10'b00_0000_0100;
  localparam logic [9:0] PHASE_DOT_PROD        = 10'b00_0000_1000;
  localparam logic [9:0] PHASE_ATTENTION       = 10'b00_0001_0000;
  localparam logic [9:0] PHASE_WEIGHTED_SUM    = 10'b00_0010_0000;
  localparam logic [9:0] PHASE_SUM_U_Q         = 10'b00_0100_0000;
  localparam logic [9:0] PHASE_FULLY_CONNECTED = 10'b00_1000_0000;
  localparam logic [9:0] PHASE_SOFT_MAX        = 10'b01_0000_0000;
  localparam logic [9:0] PHASE_END_FWD         = 10'b10_0000_0000;

  localparam int NUM_WORD_DEF  = 11;
  localparam int NUM_MEM_DEF   = 50;
  localparam int NUM_VOCAB_DEF = 20;
  localparam int DIM_EMB_DEF   = 20;
  localparam int BW_IDX_DEF    = 8;
  localparam int DRAIN_CYC_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/memn2n_nested_counter.sv
// Two-level (outer, inner) index counter, inner fastest, runtime bounds.
// Latency: load/step take effect on the next clock edge.
// Backpressure: advances only when the parent asserts i_step.
module memn2n_nested_counter #(
  parameter int BW_IDX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [BW_IDX-1:0] i_outer_max,
  input  logic [BW_IDX-1:0] i_inner_max,
  output logic [BW_IDX-1:0] o_outer,
  output logic [BW_IDX-1:0] o_inner,
  output logic              o_last,
  output logic              o_last_nxt
);

  localparam logic [BW_IDX-1:0] ONE = {{(BW_IDX-1){1'b0}}, 1'b1};

  logic [BW_IDX-1:0] r_outer, r_inner, r_outer_max, r_inner_max;
  logic              r_last;
  logic [BW_IDX-1:0] w_outer_nxt, w_inner_nxt, w_omax_nxt, w_imax_nxt;

  // next indices: load restarts at (0,0) and latches bounds for the whole loop
  always_comb begin
    w_outer_nxt = r_outer;
    w_inner_nxt = r_inner;
    w_omax_nxt  = r_outer_max;
    w_imax_nxt  = r_inner_max;
    if (i_load) begin
      w_outer_nxt = '0;
      w_inner_nxt = '0;
      w_omax_nxt  = i_outer_max;
      w_imax_nxt  = i_inner_max;
    end else if (i_step) begin
      if (r_inner == r_inner_max) begin
        w_inner_nxt = '0;
        w_outer_nxt = r_outer + ONE;
      end else begin
        w_inner_nxt = r_inner + ONE;
      end
    end
  end

  assign o_last_nxt = (w_outer_nxt == w_omax_nxt) && (w_inner_nxt == w_imax_nxt);

  // index and bound registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outer     <= '0;
      r_inner     <= '0;
      r_outer_max <= '0;
      r_inner_max <= '0;
      r_last      <= 1'b0;
    end else begin
      r_outer     <= w_outer_nxt;
      r_inner     <= w_inner_nxt;
      r_outer_max <= w_omax_nxt;
      r_inner_max <= w_imax_nxt;
      r_last      <= o_last_nxt;
    end
  end

  assign o_outer = r_outer;
  assign o_inner = r_inner;
  assign o_last  = r_last;

endmodule

// File: rtl/memn2n_phase_iterator.sv
// Per-phase nested index generator between the MemN2N phase controller and datapath.
// Latency: first request 1 cycle after phase change; done_phase 1+O*I+DRAIN_CYC cycles after entry.
// Backpressure: valid/ready; indices hold while stalled. Stall counter under MEMN2N_PHASE_ITER_STALL_CNT_EN.
module memn2n_phase_iterator
  import memn2n_phase_iterator_pkg::*;
#(
  parameter int NUM_WORD  = NUM_WORD_DEF,
  parameter int NUM_MEM   = NUM_MEM_DEF,
  parameter int NUM_VOCAB = NUM_VOCAB_DEF,
  parameter int DIM_EMB   = DIM_EMB_DEF,
  parameter int BW_IDX    = BW_IDX_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int BW_STATE  = BW_STATE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BW_STATE-1:0] memn2n_phase,
  input  logic                req_ready,
  output logic                req_valid,
  output logic [BW_IDX-1:0]   req_outer,
  output logic [BW_IDX-1:0]   req_inner,
  output logic                req_last,
  output logic                done_phase,
  output logic [31:0]         stall_cnt
);

  localparam logic [3:0] DRAIN_M1 = 4'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);

  state_e              r_state;
  logic [BW_STATE-1:0] r_phase_q;
  logic [3:0]          r_drain;
  logic                r_req_valid, r_req_last, r_done;
  logic                w_change, w_hs, w_looped, w_step, w_cnt_last, w_cnt_last_nxt;
  logic [BW_IDX-1:0]   w_omax, w_imax;

  assign w_change = (memn2n_phase != r_phase_q);
  assign w_hs     = r_req_valid && req_ready;
  assign w_step   = (r_state == S_ISSUE) && w_hs && !w_cnt_last && !w_change;

  // loop-table decode; anything not exactly one looped code runs no loop
  always_comb begin
    w_looped = 1'b0;
    w_omax   = '0;
    w_imax   = '0;
    case (memn2n_phase)
      BW_STATE'(PHASE_EMB_Q):           begin w_looped = 1'b1; w_omax = BW_IDX'(NUM_WORD-1);  w_imax = BW_IDX'(DIM_EMB-1); end
      BW_STATE'(PHASE_DOT_PROD):        begin w_looped = 1'b1; w_omax = BW_IDX'(NUM_MEM-1);   w_imax = BW_IDX'(DIM_EMB-1); end
      BW_STATE'(PHASE_ATTENTION):       begin w_looped = 1'b1; w_omax = BW_IDX'(NUM_MEM-1);   w_imax = '0; end
      BW_STATE'(PHASE_WEIGHTED_SUM):    begin w_looped = 1'b1; w_omax = BW_IDX'(NUM_MEM-1);   w_imax = BW_IDX'(DIM_EMB-1); end
      BW_STATE'(PHASE_FULLY_CONNECTED): begin w_looped = 1'b1; w_omax = BW_IDX'(NUM_VOCAB-1); w_imax = BW_IDX'(DIM_EMB-1); end
      BW_STATE'(PHASE_SOFT_MAX):        begin w_looped = 1'b1; w_omax = BW_IDX'(NUM_VOCAB-1); w_imax = '0; end
      default: ;
    endcase
  end

  memn2n_nested_counter #(.BW_IDX(BW_IDX)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_change),
    .i_step      (w_step),
    .i_outer_max (w_omax),
    .i_inner_max (w_imax),
    .o_outer     (req_outer),
    .o_inner     (req_inner),
    .o_last      (w_cnt_last),
    .o_last_nxt  (w_cnt_last_nxt)
  );

  // phase tracking FSM; a phase change overrides every state and suppresses done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase_q   <= BW_STATE'(PHASE_IDLE);
      r_drain     <= '0;
      r_req_valid <= 1'b0;
      r_req_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_phase_q <= memn2n_phase;
      r_done    <= 1'b0;
      if (w_change) begin
        r_req_valid <= w_looped;
        r_req_last  <= w_looped && w_cnt_last_nxt;
        r_state     <= w_looped ? S_ISSUE : S_IDLE;
      end else begin
        case (r_state)
          S_ISSUE: begin
            if (w_hs) begin
              if (w_cnt_last) begin
                r_req_valid <= 1'b0;
                r_req_last  <= 1'b0;
                if (DRAIN_CYC == 0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_DRAIN;
                  r_drain <= DRAIN_M1;
                end
              end else begin
                r_req_last <= w_cnt_last_nxt;
              end
            end
          end
          S_DRAIN: begin
            if (r_drain == 4'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_drain <= r_drain - 4'd1;
            end
          end
          S_DONE:  r_state <= S_WAIT;
          S_IDLE, S_WAIT: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign req_valid  = r_req_valid;
  assign req_last   = r_req_last;
  assign done_phase = r_done;

`ifdef MEMN2N_PHASE_ITER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // count cycles a valid request is held off, saturating, restarted per phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_change) begin
      r_stall_cnt <= '0;
    end else if (r_req_valid && !req_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
